// File: rtl/mem_types_pkg.sv
// Shared memory-interface types for the icache / backing-RAM path.
// Holds the block and word types, plus the FSM encoding and timeout-counter width for imem_responder.
package mem_types_pkg;

    typedef logic [28:0] block_addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RESP = 3'd3,
        PF0  = 3'd4,
        PF1  = 3'd5
    } imem_resp_state_t;

    localparam int IMEM_RESP_TIMEOUT_W = 8;

    // Block addresses wrap modulo 2^29, so 0x1FFFFFFF is followed by 0.
    function automatic block_addr_t next_block(input block_addr_t blk);
        return blk + 1'b1;
    endfunction

    function automatic word_t word_byte_addr(input block_addr_t blk, input logic off);
        return {blk, off, 2'b00};
    endfunction

endpackage

// File: rtl/imem_responder.sv
// Memory-side responder for icache block reads: two RAM word reads per block, one registered imem_hit.
// Optional next-block prefetch buffer is enabled by defining IMEM_PREFETCH_EN.
module imem_responder
    import mem_types_pkg::*;
#(
    parameter int RAM_TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             DUT_error,
    input  logic             imem_REN,
    input  logic [28:0]      imem_block_addr,
    output logic             imem_hit,
    output logic [1:0][31:0] imem_load,
    output logic             ram_REN,
    output logic [31:0]      ram_addr,
    input  logic             ram_ready,
    input  logic [31:0]      ram_load
);

    localparam logic [IMEM_RESP_TIMEOUT_W-1:0] TMO_LAST = IMEM_RESP_TIMEOUT_W'(RAM_TIMEOUT - 1);
    localparam logic [IMEM_RESP_TIMEOUT_W-1:0] TMO_SAT  = '1;

    imem_resp_state_t                 state_reg, state_next;
    block_addr_t                      addr_reg, addr_next;
    word_t                            word0_reg, word0_next;
    logic                             abort_reg, abort_next;
    logic [IMEM_RESP_TIMEOUT_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic                             err_reg, err_next;
    logic                             hit_reg, hit_next;
    logic [1:0][31:0]                 load_reg, load_next;
    logic                             req_changed;

`ifdef IMEM_PREFETCH_EN
    logic                             pf_valid_reg, pf_valid_next;
    block_addr_t                      pf_addr_reg, pf_addr_next;
    logic [1:0][31:0]                 pf_block_reg, pf_block_next;
    logic                             pf_conflict;

    // Any live request for a block other than the one being prefetched kills the prefetch.
    assign pf_conflict = imem_REN && (imem_block_addr != pf_addr_reg);
`endif

    assign req_changed = !imem_REN || (imem_block_addr != addr_reg);

    assign DUT_error = err_reg;
    assign imem_hit  = hit_reg;
    assign imem_load = load_reg;

    always_comb begin
        ram_REN  = 1'b0;
        ram_addr = '0;
        case (state_reg)
            RD0: begin
                ram_REN  = 1'b1;
                ram_addr = word_byte_addr(addr_reg, 1'b0);
            end
            RD1: begin
                ram_REN  = 1'b1;
                ram_addr = word_byte_addr(addr_reg, 1'b1);
            end
`ifdef IMEM_PREFETCH_EN
            PF0: begin
                ram_REN  = 1'b1;
                ram_addr = word_byte_addr(pf_addr_reg, 1'b0);
            end
            PF1: begin
                ram_REN  = 1'b1;
                ram_addr = word_byte_addr(pf_addr_reg, 1'b1);
            end
`endif
            default: begin
                ram_REN  = 1'b0;
                ram_addr = '0;
            end
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        word0_next   = word0_reg;
        abort_next   = abort_reg;
        hit_next     = 1'b0;
        load_next    = '0;
        err_next     = 1'b0;
        tmo_cnt_next = '0;
`ifdef IMEM_PREFETCH_EN
        pf_valid_next = pf_valid_reg;
        pf_addr_next  = pf_addr_reg;
        pf_block_next = pf_block_reg;
`endif

        // Stall counter saturates, so a stuck RAM yields exactly one error pulse per word.
        if (ram_REN && !ram_ready) begin
            tmo_cnt_next = (tmo_cnt_reg == TMO_SAT) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;
            err_next     = (tmo_cnt_reg == TMO_LAST);
        end

        case (state_reg)
            IDLE: begin
`ifdef IMEM_PREFETCH_EN
                if (imem_REN && pf_valid_reg && (imem_block_addr == pf_addr_reg)) begin
                    hit_next      = 1'b1;
                    load_next     = pf_block_reg;
                    pf_valid_next = 1'b0;
                    pf_addr_next  = next_block(pf_addr_reg);
                    state_next    = PF0;
                end else
`endif
                if (imem_REN) begin
                    addr_next  = imem_block_addr;
                    abort_next = 1'b0;
                    state_next = RD0;
                end
            end
            RD0: begin
                if (req_changed) begin
                    abort_next = 1'b1;
                end
                if (ram_ready) begin
                    if (abort_reg || req_changed) begin
                        abort_next = 1'b0;
                        state_next = IDLE;
                    end else begin
                        word0_next = ram_load;
                        state_next = RD1;
                    end
                end
            end
            RD1: begin
                if (req_changed) begin
                    abort_next = 1'b1;
                end
                if (ram_ready) begin
                    if (abort_reg || req_changed) begin
                        abort_next = 1'b0;
                        state_next = IDLE;
                    end else begin
                        hit_next   = 1'b1;
                        load_next  = {ram_load, word0_reg};
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
`ifdef IMEM_PREFETCH_EN
                pf_valid_next = 1'b0;
                pf_addr_next  = next_block(addr_reg);
                state_next    = PF0;
`else
                state_next    = IDLE;
`endif
            end
`ifdef IMEM_PREFETCH_EN
            PF0, PF1: begin
                if (pf_conflict) begin
                    abort_next = 1'b1;
                end
                if (ram_ready) begin
                    if (abort_reg || pf_conflict) begin
                        // The in-flight word is done; hand the real request straight to RD0.
                        abort_next    = 1'b0;
                        pf_valid_next = 1'b0;
                        if (imem_REN) begin
                            addr_next  = imem_block_addr;
                            state_next = RD0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else if (state_reg == PF0) begin
                        pf_block_next[0] = ram_load;
                        state_next       = PF1;
                    end else begin
                        pf_block_next[1] = ram_load;
                        pf_valid_next    = 1'b1;
                        state_next       = IDLE;
                    end
                end
            end
`endif
            default: begin
                err_next   = 1'b1;
                abort_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            word0_reg   <= '0;
            abort_reg   <= 1'b0;
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b0;
            hit_reg     <= 1'b0;
            load_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            word0_reg   <= word0_next;
            abort_reg   <= abort_next;
            tmo_cnt_reg <= tmo_cnt_next;
            err_reg     <= err_next;
            hit_reg     <= hit_next;
            load_reg    <= load_next;
        end
    end

`ifdef IMEM_PREFETCH_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            pf_valid_reg <= 1'b0;
            pf_addr_reg  <= '0;
            pf_block_reg <= '0;
        end else begin
            pf_valid_reg <= pf_valid_next;
            pf_addr_reg  <= pf_addr_next;
            pf_block_reg <= pf_block_next;
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: RAM model with programmable stalls, block-level reference model.
// Latency expectations follow the IMEM_PREFETCH_EN setting of the build.
module tb_imem_responder;
    import mem_types_pkg::*;

    localparam int RAM_TIMEOUT = 255;
    localparam int HIT_BOUND   = 1000;

    logic             CLK = 1'b0;
    logic             RST;
    logic             DUT_error;
    logic             imem_REN;
    logic [28:0]      imem_block_addr;
    logic             imem_hit;
    logic [1:0][31:0] imem_load;
    logic             ram_REN;
    logic [31:0]      ram_addr;
    logic             ram_ready;
    logic [31:0]      ram_load;

    imem_responder #(.RAM_TIMEOUT(RAM_TIMEOUT)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .DUT_error       (DUT_error),
        .imem_REN        (imem_REN),
        .imem_block_addr (imem_block_addr),
        .imem_hit        (imem_hit),
        .imem_load       (imem_load),
        .ram_REN         (ram_REN),
        .ram_addr        (ram_addr),
        .ram_ready       (ram_ready),
        .ram_load        (ram_load)
    );

    always #5 CLK = ~CLK;

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t mem_ovr [word_t];
    int    delay_q [$];
    int    dflt_stall = 0;
    word_t ram_log [$];
    int    viol = 0;
    int    err_pulses = 0;
    int    req_err_cnt;
    int    req_err_lat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Backing RAM contents: a fixed scramble of the byte address unless overridden.
    function automatic word_t mem_word(input word_t a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[15:0] ^ 16'h3C5A, a[31:16] ^ {a[7:0], a[15:8]}};
    endfunction

    function automatic logic [63:0] block_data(input logic [28:0] blk);
        return {mem_word({blk, 3'b100}), mem_word({blk, 3'b000})};
    endfunction

    // RAM model and protocol monitor, evaluated just after each falling edge.
    initial begin
        int    pend;
        logic  prev_ren, prev_ready, prev_rst;
        word_t prev_addr;
        pend = -1;
        prev_ren = 1'b0; prev_ready = 1'b0; prev_rst = 1'b1; prev_addr = '0;
        ram_ready = 1'b0;
        ram_load  = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (prev_ren && !prev_ready && !prev_rst && (!ram_REN || ram_addr != prev_addr)) viol++;
            if (DUT_error) err_pulses++;
            ram_ready = 1'b0;
            if (RST) begin
                pend = -1;
                delay_q.delete();
            end else if (ram_REN) begin
                if (pend < 0) begin
                    if (delay_q.size() > 0) pend = delay_q.pop_front();
                    else if (dflt_stall < 0) pend = int'($urandom_range(3, 0));
                    else pend = dflt_stall;
                end
                if (pend == 0) begin
                    ram_ready = 1'b1;
                    ram_load  = mem_word(ram_addr);
                    ram_log.push_back(ram_addr);
                    pend = -1;
                end else begin
                    pend--;
                end
            end else begin
                pend = -1;
            end
            prev_ren = ram_REN; prev_ready = ram_ready; prev_rst = RST; prev_addr = ram_addr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Present a block request at a falling edge and wait for its hit.
    task automatic request(input logic [28:0] a, input bit keep, input bit chk_log, output int lat);
        bit got;
        ram_log.delete();
        imem_REN = 1'b1;
        imem_block_addr = a;
        got = 1'b0;
        lat = 0;
        req_err_cnt = 0;
        req_err_lat = -1;
        while (!got && lat < HIT_BOUND) begin
            @(negedge CLK);
            lat++;
            if (DUT_error) begin
                if (req_err_cnt == 0) req_err_lat = lat;
                req_err_cnt++;
            end
            if (imem_hit) got = 1'b1;
        end
        chk("hit_seen", 64'(got), 64'd1);
        chk("load", imem_load, block_data(a));
        if (chk_log) begin
`ifndef IMEM_PREFETCH_EN
            chk("ram_reads", 64'(ram_log.size()), 64'd2);
            if (ram_log.size() == 2) begin
                chk("ram_addr0", 64'(ram_log[0]), 64'({a, 3'b000}));
                chk("ram_addr1", 64'(ram_log[1]), 64'({a, 3'b100}));
            end
`endif
        end
        $display("txn addr=0x%07h load=0x%016h lat=%0d", a, imem_load, lat);
        if (!keep) imem_REN = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 400) begin
            @(negedge CLK);
            n++;
            quiet = ram_REN ? 0 : quiet + 1;
        end
        chk("idle_reached", 64'(quiet >= 3), 64'd1);
    endtask

    initial begin
        int lat;
        int hits;
        int ren_cyc;
        int found;
        bool_dummy: begin end
        RST = 1'b1;
        imem_REN = 1'b0;
        imem_block_addr = '0;
        repeat (3) @(negedge CLK);
        chk("rst_hit", 64'(imem_hit), 64'd0);
        chk("rst_load", imem_load, 64'd0);
        chk("rst_ram_ren", 64'(ram_REN), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_error", 64'(DUT_error), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // 1: single block, zero-stall RAM
        mem_ovr[32'h80] = 32'hAAAA0000;
        mem_ovr[32'h84] = 32'hBBBB0001;
        dflt_stall = 0;
        request(29'h10, 1'b0, 1'b1, lat);
        chk("t1_lat", 64'(lat), 64'd3);
        chk("t1_load", imem_load, 64'hBBBB0001_AAAA0000);
        wait_idle();

        // 2: eight consecutive blocks, address stepped right after each hit
        dflt_stall = -1;
        for (int i = 0; i < 8; i++) begin
            request(29'h10 + 29'(i), (i < 7), 1'b1, lat);
        end
        wait_idle();

        // 3: REN dropped while the second word stalls
        dflt_stall = 0;
        delay_q.push_back(0);
        delay_q.push_back(3);
        ram_log.delete();
        imem_REN = 1'b1;
        imem_block_addr = 29'h40;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge CLK);
            if (ram_REN && ram_addr == {29'h40, 3'b100}) found = 1;
        end
        chk("t3_rd1_seen", 64'(found), 64'd1);
        imem_REN = 1'b0;
        hits = 0;
        ren_cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (imem_hit) hits++;
            if (ram_REN) ren_cyc++;
        end
        chk("t3_no_hit", 64'(hits), 64'd0);
        chk("t3_ren_held", 64'(ren_cyc), 64'd3);
        chk("t3_ram_reads", 64'(ram_log.size()), 64'd2);
        chk("t3_idle", 64'(ram_REN), 64'd0);

        // 3b: address changed in RD0; the new block must be served, not the old one
        delay_q.push_back(2);
        imem_REN = 1'b1;
        imem_block_addr = 29'h50;
        @(negedge CLK);
        request(29'h51, 1'b0, 1'b0, lat);
        wait_idle();

        // 4: RAM stalls 300 cycles on word 0
        delay_q.push_back(300);
        delay_q.push_back(0);
        request(29'h60, 1'b0, 1'b1, lat);
        chk("t4_lat", 64'(lat), 64'd303);
        chk("t4_err_pulses", 64'(req_err_cnt), 64'd1);
        chk("t4_err_at", 64'(req_err_lat), 64'(RAM_TIMEOUT + 1));
        wait_idle();

        // 5: reset during RD0
        delay_q.push_back(5);
        imem_REN = 1'b1;
        imem_block_addr = 29'h30;
        @(negedge CLK);
        chk("t5_in_rd0", 64'(ram_REN), 64'd1);
        RST = 1'b1;
        imem_REN = 1'b0;
        @(negedge CLK);
        chk("t5_ren_off", 64'(ram_REN), 64'd0);
        chk("t5_no_hit", 64'(imem_hit), 64'd0);
        RST = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (imem_hit || ram_REN) hits++;
        end
        chk("t5_quiet", 64'(hits), 64'd0);
        request(29'h20, 1'b0, 1'b1, lat);
        chk("t5_lat", 64'(lat), 64'd3);
        wait_idle();

        // 6: top block, then wrap to block 0
        request(29'h1FFFFFFF, 1'b0, 1'b1, lat);
        chk("t6_lat_top", 64'(lat), 64'd3);
        wait_idle();
`ifdef IMEM_PREFETCH_EN
        request(29'h0, 1'b1, 1'b0, lat);
        chk("t6_pf_lat", 64'(lat), 64'd1);
        request(29'h123, 1'b0, 1'b0, lat);
        chk("t6_pf_cancel_lat", 64'(lat), 64'd3);
`else
        request(29'h0, 1'b0, 1'b1, lat);
        chk("t6_wrap_lat", 64'(lat), 64'd3);
`endif
        wait_idle();

        // 7: randomized traffic against the block-level model
        begin
            logic [28:0] a;
            bit          keep;
            bit          prev_keep;
            int          s0, s1, sel;
            a = 29'h1000;
            prev_keep = 1'b0;
            dflt_stall = -1;
            for (int t = 0; t < 40; t++) begin
                sel = int'($urandom_range(9, 0));
                if (sel < 5) a = a + 29'd1;
                else if (sel == 5) a = 29'h1FFFFFFF;
                else a = 29'($urandom);
                keep = 1'($urandom_range(1, 0));
                s0 = int'($urandom_range(3, 0));
                s1 = int'($urandom_range(3, 0));
`ifndef IMEM_PREFETCH_EN
                delay_q.push_back(s0);
                delay_q.push_back(s1);
`endif
                request(a, keep, 1'b1, lat);
`ifndef IMEM_PREFETCH_EN
                chk("rnd_lat", 64'(lat), 64'((prev_keep ? 4 : 3) + s0 + s1));
`endif
                if (!keep) repeat (1 + $urandom_range(2, 0)) @(negedge CLK);
                prev_keep = keep;
            end
            imem_REN = 1'b0;
            wait_idle();
        end

        chk("ram_protocol", 64'(viol), 64'd0);
        chk("err_total", 64'(err_pulses), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
